// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_ctrl_pkg: FPU op codes, unit map and latency table shared by the issue controller.
package fpu_ctrl_pkg;
  localparam int OP_FMADD = 0, OP_FMSUB = 1, OP_FADD = 2, OP_FMUL = 3, OP_FMV = 4;
  localparam int OP_FSGNJ = 5, OP_FDIV = 6, OP_FCMP = 7, OP_FCVT_W = 8, OP_FCVT_S = 9;
  localparam int U_ADD = 0, U_MUL = 1, U_DIV = 2, U_MISC = 3;
  localparam int MAX_LAT = 16;
  function automatic int fpu_lat(input int op);
    case (op)
      OP_FMADD, OP_FMSUB:   return 7;
      OP_FADD:              return 5;
      OP_FMUL:              return 6;
      OP_FSGNJ, OP_FCMP:    return 1;
      OP_FDIV:              return 16;
      OP_FCVT_W, OP_FCVT_S: return 6;
      default:              return 0;
    endcase
  endfunction
  function automatic int fpu_unit(input int op);
    case (op)
      OP_FMADD, OP_FMSUB, OP_FMUL: return U_MUL;
      OP_FDIV:                     return U_DIV;
      OP_FMV, OP_FSGNJ, OP_FCMP,
      OP_FCVT_W, OP_FCVT_S:        return U_MISC;
      default:                     return U_ADD;
    endcase
  endfunction
  function automatic bit lat_fits(input int cnt_w);
    return MAX_LAT <= (1 << cnt_w) - 1;
  endfunction
endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: EX-stage request and write-back status bundle for the FPU issue controller.
interface fpu_issue_ctrl_if #(parameter int NUM_UNITS = 4, parameter int OP_W = 4, parameter int TAG_W = 5);
  localparam int UW = $clog2(NUM_UNITS);
  logic fpu_sel;
  logic [OP_W-1:0] fpu_op;
  logic [TAG_W-1:0] fpu_rd;
  logic fpu_rd_we;
  logic [TAG_W-1:0] fpu_rs1;
  logic [TAG_W-1:0] fpu_rs2;
  logic flush;
  logic fpu_stall;
  logic fpu_issue;
  logic [NUM_UNITS-1:0] unit_busy;
  logic wb_valid;
  logic [UW-1:0] wb_unit;
  logic [TAG_W-1:0] wb_tag;
  modport master (
    output fpu_sel, fpu_op, fpu_rd, fpu_rd_we, fpu_rs1, fpu_rs2, flush,
    input  fpu_stall, fpu_issue, unit_busy, wb_valid, wb_unit, wb_tag
  );
  modport slave (
    input  fpu_sel, fpu_op, fpu_rd, fpu_rd_we, fpu_rs1, fpu_rs2, flush,
    output fpu_stall, fpu_issue, unit_busy, wb_valid, wb_unit, wb_tag
  );
endinterface

// File: rtl/fpu_unit_timer.sv
// fpu_unit_timer: per-unit latency counter with destination tag; write-enable tracking only with FPU_SCOREBOARD_EN.
module fpu_unit_timer #(parameter int CNT_W = 5, parameter int TAG_W = 5) (
  input  logic clock,
  input  logic clear,
  input  logic load,
  input  logic grant,
  input  logic flush,
  input  logic [CNT_W-1:0] lat,
  input  logic [TAG_W-1:0] rd,
`ifdef FPU_SCOREBOARD_EN
  input  logic rd_we,
  output logic writer,
`endif
  output logic [TAG_W-1:0] tag,
  output logic counting,
  output logic pending,
  output logic busy
);
  logic [CNT_W-1:0] cnt;
  assign counting = cnt > CNT_W'(1);
  assign pending = cnt == CNT_W'(1);
  assign busy = |cnt;
  // an ungranted unit parks at cnt==1 until the arbiter picks it
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      cnt <= '0;
      tag <= '0;
    end else if (flush) cnt <= '0;
    else if (load) begin
      cnt <= lat;
      tag <= rd;
    end else if (counting) cnt <= cnt - CNT_W'(1);
    else if (grant) cnt <= '0;
`ifdef FPU_SCOREBOARD_EN
  logic we;
  always_ff @(posedge clock or posedge clear)
    if (clear) we <= 1'b0;
    else if (load && !flush) we <= rd_we;
  assign writer = busy & we;
`endif
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: FPU issue/stall control with per-unit timers and write-back arbiter.
// FPU_SCOREBOARD_EN selects overlapped issue with RAW/WAW scoreboard; otherwise one op in flight.
module fpu_issue_ctrl import fpu_ctrl_pkg::*; #(
  parameter int NUM_UNITS = 4,
  parameter int OP_W = 4,
  parameter int CNT_W = 5,
  parameter int TAG_W = 5
) (
  input logic clock,
  input logic clear,
  fpu_issue_ctrl_if.slave bus
);
  localparam int UW = $clog2(NUM_UNITS);
  if (!lat_fits(CNT_W)) begin : g_chk
    $error("CNT_W too narrow for the longest FPU latency");
  end
  logic [TAG_W-1:0] tag [NUM_UNITS];
  logic [NUM_UNITS-1:0] counting, pending, busy, grant, load;
  logic [CNT_W-1:0] lat;
  logic [UW-1:0] unit, win;
  logic tracked;
  assign lat = CNT_W'(fpu_lat(int'(bus.fpu_op)));
  assign unit = UW'(fpu_unit(int'(bus.fpu_op)));
  assign tracked = |lat;
`ifdef FPU_SCOREBOARD_EN
  logic [NUM_UNITS-1:0] writer, raw, waw;
  logic structural;
`endif
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    fpu_unit_timer #(.CNT_W(CNT_W), .TAG_W(TAG_W)) u_timer (
      .clock(clock),
      .clear(clear),
      .load(load[i]),
      .grant(grant[i]),
      .flush(bus.flush),
      .lat(lat),
      .rd(bus.fpu_rd),
`ifdef FPU_SCOREBOARD_EN
      .rd_we(bus.fpu_rd_we),
      .writer(writer[i]),
`endif
      .tag(tag[i]),
      .counting(counting[i]),
      .pending(pending[i]),
      .busy(busy[i])
    );
  end
`ifdef FPU_SCOREBOARD_EN
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_haz
    assign raw[i] = writer[i] && (tag[i] == bus.fpu_rs1 || tag[i] == bus.fpu_rs2);
    assign waw[i] = writer[i] && bus.fpu_rd_we && tag[i] == bus.fpu_rd;
  end
  // lowest pending index wins; a granted unit may be reloaded in the same cycle
  assign grant = bus.flush ? '0 : pending & (~pending + NUM_UNITS'(1));
  assign structural = counting[unit] || (pending[unit] && !grant[unit]);
  assign bus.fpu_stall = bus.fpu_sel && tracked && (structural || (|raw) || (|waw));
  assign bus.fpu_issue = bus.fpu_sel && tracked && !bus.fpu_stall;
`else
  // the op stays in EX while its unit counts down and leaves on its write-back cycle
  assign grant = bus.flush ? '0 : pending;
  assign bus.fpu_stall = bus.fpu_sel && tracked && (!(|busy) || (|counting));
  assign bus.fpu_issue = bus.fpu_sel && tracked && !(|busy);
`endif
  always_comb begin
    win = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) if (pending[i]) win = UW'(i);
  end
  assign load = (bus.fpu_issue && !bus.flush) ? NUM_UNITS'(1) << unit : '0;
  assign bus.unit_busy = busy;
  assign bus.wb_valid = (|pending) && !bus.flush;
  assign bus.wb_unit = bus.wb_valid ? win : '0;
  assign bus.wb_tag = bus.wb_valid ? tag[win] : '0;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scoreboard bench for fpu_issue_ctrl.
// Define FPU_SCOREBOARD_EN to exercise overlapped mode; default exercises blocking mode.
module tb_fpu_issue_ctrl;
  import fpu_ctrl_pkg::*;
  typedef struct {int cyc; int unit; int tag;} wb_t;
  logic clock = 1'b0;
  logic clear = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  wb_t sb[$];
  fpu_issue_ctrl_if #(.NUM_UNITS(4), .OP_W(4), .TAG_W(5)) bus();
  fpu_issue_ctrl dut(.clock(clock), .clear(clear), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic drive(input logic s, input int op, input int rd, input int rs1 = 0, input int rs2 = 0, input logic we = 1'b1);
    bus.fpu_sel = s;
    bus.fpu_op = 4'(op);
    bus.fpu_rd = 5'(rd);
    bus.fpu_rs1 = 5'(rs1);
    bus.fpu_rs2 = 5'(rs2);
    bus.fpu_rd_we = we;
  endtask
  task automatic expect_wb(input int dly, input int unit, input int tag);
    sb.push_back('{cyc + dly, unit, tag});
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_stall"}, 32'(bus.fpu_stall), 0);
    chk({name, "_issue"}, 32'(bus.fpu_issue), 0);
    chk({name, "_busy"}, 32'(bus.unit_busy), 0);
    chk({name, "_wb_valid"}, 32'(bus.wb_valid), 0);
    chk({name, "_wb_unit"}, 32'(bus.wb_unit), 0);
    chk({name, "_wb_tag"}, 32'(bus.wb_tag), 0);
  endtask
  task automatic run_op(input int op, input int rd, input int lat, input int unit);
    drive(1'b1, op, rd);
    expect_wb(lat, unit, rd);
    for (int k = 0; k <= lat; k++) begin
      #2;
      chk("blk_stall", 32'(bus.fpu_stall), 32'(k < lat));
      chk("blk_issue", 32'(bus.fpu_issue), 32'(k == 0));
      chk("blk_busy", 32'(bus.unit_busy), k == 0 ? 0 : 1 << unit);
      chk("blk_wb_valid", 32'(bus.wb_valid), 32'(k == lat));
      tick();
    end
    drive(1'b0, 0, 0);
  endtask
  always @(negedge clock) if (!clear && bus.wb_valid) begin
    int idx;
    idx = -1;
    foreach (sb[k]) if (sb[k].cyc == cyc) idx = k;
    chk("wb_expected", 32'(idx >= 0), 1);
    if (idx >= 0) begin
      chk("wb_unit", 32'(bus.wb_unit), sb[idx].unit);
      chk("wb_tag", 32'(bus.wb_tag), sb[idx].tag);
      sb.delete(idx);
    end
  end
  initial begin
    drive(1'b0, 0, 0);
    bus.flush = 1'b0;
    tick(2);
    chk_idle("reset");
    clear = 1'b0;
    tick();
    drive(1'b1, OP_FDIV, 3);
    #2;
    chk("div_issue", 32'(bus.fpu_issue), 1);
    tick();
    drive(1'b0, 0, 0);
    tick(2);
    chk("div_busy", 32'(bus.unit_busy), 32'b0100);
    #1 clear = 1'b1;
    #1;
    chk_idle("async_clear");
    tick();
    clear = 1'b0;
    tick();
`ifdef FPU_SCOREBOARD_EN
    drive(1'b1, OP_FADD, 5);
    #2;
    chk("add_issue", 32'(bus.fpu_issue), 1);
    expect_wb(5, U_ADD, 5);
    tick();
    drive(1'b0, 0, 0);
    tick(8);
    drive(1'b1, OP_FDIV, 3);
    #2;
    chk("ovl_div_stall", 32'(bus.fpu_stall), 0);
    chk("ovl_div_issue", 32'(bus.fpu_issue), 1);
    expect_wb(16, U_DIV, 3);
    tick();
    drive(1'b1, OP_FADD, 4, 10, 11);
    #2;
    chk("ovl_add_stall", 32'(bus.fpu_stall), 0);
    chk("ovl_add_issue", 32'(bus.fpu_issue), 1);
    expect_wb(5, U_ADD, 4);
    tick();
    drive(1'b0, 0, 0);
    #2;
    chk("ovl_busy", 32'(bus.unit_busy), 32'b0101);
    tick(18);
    drive(1'b1, OP_FMUL, 7);
    #2;
    chk("raw_first_issue", 32'(bus.fpu_issue), 1);
    expect_wb(6, U_MUL, 7);
    tick();
    drive(1'b1, OP_FADD, 8, 7);
    for (int k = 1; k <= 7; k++) begin
      #2;
      chk("raw_stall", 32'(bus.fpu_stall), 32'(k < 7));
      chk("raw_issue", 32'(bus.fpu_issue), 32'(k == 7));
      if (k == 7) expect_wb(5, U_ADD, 8);
      tick();
    end
    drive(1'b0, 0, 0);
    tick(8);
    drive(1'b1, OP_FMUL, 12);
    expect_wb(7, U_MUL, 12);
    tick();
    drive(1'b1, OP_FADD, 13);
    #2;
    chk("arb_add_issue", 32'(bus.fpu_issue), 1);
    expect_wb(5, U_ADD, 13);
    tick();
    drive(1'b0, 0, 0);
    tick(5);
    chk("arb_mul_hold", 32'(bus.unit_busy), 32'b0010);
    tick();
    chk("arb_mul_done", 32'(bus.unit_busy), 0);
    tick(2);
    drive(1'b1, OP_FMUL, 9);
    expect_wb(6, U_MUL, 9);
    tick();
    drive(1'b1, OP_FADD, 9);
    #2;
    chk("waw_stall", 32'(bus.fpu_stall), 1);
    drive(1'b1, OP_FADD, 9, 0, 0, 1'b0);
    #1;
    chk("waw_nowe_stall", 32'(bus.fpu_stall), 0);
    chk("waw_nowe_issue", 32'(bus.fpu_issue), 1);
    expect_wb(5, U_ADD, 9);
    tick();
    drive(1'b0, 0, 0);
    tick(8);
    drive(1'b1, OP_FADD, 14);
    expect_wb(5, U_ADD, 14);
    tick();
    drive(1'b1, OP_FADD, 15);
    #2;
    chk("struct_stall", 32'(bus.fpu_stall), 1);
    drive(1'b0, 0, 0);
    tick(4);
    drive(1'b1, OP_FADD, 17);
    #2;
    chk("b2b_stall", 32'(bus.fpu_stall), 0);
    chk("b2b_issue", 32'(bus.fpu_issue), 1);
    expect_wb(5, U_ADD, 17);
    tick();
    drive(1'b0, 0, 0);
    tick(8);
    drive(1'b1, OP_FMUL, 7);
    expect_wb(6, U_MUL, 7);
    tick();
    drive(1'b1, OP_FMV, 1, 7);
    #2;
    chk("l0_raw_stall", 32'(bus.fpu_stall), 0);
    drive(1'b0, 0, 0);
    tick(8);
    drive(1'b1, OP_FDIV, 3);
    tick();
    drive(1'b1, OP_FMUL, 20);
    tick();
    drive(1'b0, 0, 0);
    tick();
    bus.flush = 1'b1;
    #2;
    chk("flush_wb", 32'(bus.wb_valid), 0);
    chk("flush_busy", 32'(bus.unit_busy), 32'b0110);
    tick();
    bus.flush = 1'b0;
    #2;
    chk("post_flush_busy", 32'(bus.unit_busy), 0);
    tick(20);
`else
    run_op(OP_FADD, 5, 5, U_ADD);
    run_op(OP_FDIV, 3, 16, U_DIV);
    run_op(OP_FSGNJ, 6, 1, U_MISC);
    run_op(OP_FMUL, 11, 6, U_MUL);
    drive(1'b1, OP_FMV, 1);
    #2;
    chk("l0_stall", 32'(bus.fpu_stall), 0);
    chk("l0_busy", 32'(bus.unit_busy), 0);
    drive(1'b1, 12, 1);
    #1;
    chk("bad_op_stall", 32'(bus.fpu_stall), 0);
    tick();
    drive(1'b1, OP_FDIV, 2);
    expect_wb(16, U_DIV, 2);
    tick();
    drive(1'b1, OP_FMV, 1, 2);
    #2;
    chk("l0_inflight_stall", 32'(bus.fpu_stall), 0);
    chk("l0_inflight_busy", 32'(bus.unit_busy), 32'b0100);
    drive(1'b0, 0, 0);
    tick(17);
    drive(1'b1, OP_FMUL, 20);
    #2;
    chk("flush_op_issue", 32'(bus.fpu_issue), 1);
    tick(3);
    drive(1'b0, 0, 0);
    bus.flush = 1'b1;
    #2;
    chk("flush_wb", 32'(bus.wb_valid), 0);
    chk("flush_busy", 32'(bus.unit_busy), 32'b0010);
    tick();
    bus.flush = 1'b0;
    #2;
    chk("post_flush_busy", 32'(bus.unit_busy), 0);
    tick(10);
`endif
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
